// File: rtl/mem_access_unit_if.sv
// Avalon-style memory port between the access unit (master) and system RAM (slave).
interface mem_access_unit_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: turns one byte/half/word request into a single Avalon
// transaction, extends load data and flags misalignment, illegal ops and timeouts.
module mem_access_unit #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_FAULT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] address_q, address_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] load_q, load_d;
  logic [15:0] cnt_q, cnt_d;

  function automatic logic op_legal(input logic [3:0] o);
    case (o)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10: op_legal = 1'b1;
      default:                                         op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b01:   misaligned = lo[0];
      2'b10:   misaligned = (lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   lane_enables = 4'b0001 << lo;
      2'b01:   lane_enables = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   replicate = {4{d[7:0]}};
      2'b01:   replicate = {2{d[15:0]}};
      default: replicate = d;
    endcase
  endfunction

  // op bit 2 selects zero extension; bits 1:0 give the access size
  function automatic logic [31:0] extend(input logic [2:0] o, input logic [1:0] lo,
                                         input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (o[1:0])
      2'b00:   extend = o[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   extend = o[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: extend = rd;
    endcase
  endfunction

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= 3'd0;
      lo_q      <= 2'd0;
      address_q <= 32'd0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      load_q    <= 32'd0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      lo_q      <= lo_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      read_q    <= read_d;
      write_q   <= write_d;
      done_q    <= done_d;
      err_q     <= err_d;
      load_q    <= load_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and bus field derivation
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    lo_d      = lo_q;
    address_d = address_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    read_d    = read_q;
    write_d   = write_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    load_d    = load_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_legal(op) && !misaligned(op[1:0], addr[1:0])) begin
            state_d   = S_ACCESS;
            op_d      = op[2:0];
            lo_d      = addr[1:0];
            address_d = {addr[31:2], 2'b00};
            be_d      = lane_enables(op[1:0], addr[1:0]);
            wdata_d   = replicate(op[1:0], store_data);
            read_d    = ~op[3];
            write_d   = op[3];
            cnt_d     = 16'd0;
          end else begin
            // done is raised while FAULT is held so it lands one cycle after start
            state_d = S_FAULT;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (!bus.waitrequest) begin
          if (read_q) begin
            load_d = extend(op_q, lo_q, bus.readdata);
          end else begin
            load_d = load_q;
          end
          read_d  = 1'b0;
          write_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if ((TIMEOUT_CYCLES != 16'd0) && (cnt_d == TIMEOUT_CYCLES)) begin
            read_d  = 1'b0;
            write_d = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_FAULT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;
  assign err             = err_q;
  assign load_data       = load_q;
  assign bus.address     = address_q;
  assign bus.read        = read_q;
  assign bus.write       = write_q;
  assign bus.byteenable  = be_q;
  assign bus.writedata   = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: default-timeout instance plus a TIMEOUT_CYCLES=4 instance.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0;
  logic        start_t = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] sd = 32'd0;
  logic        busy_a, done_a, err_a, busy_t, done_t, err_t;
  logic [31:0] ld_a, ld_t;
  int          n_checks = 0;
  int          n_fail = 0;

  mem_access_unit_if bus_a();
  mem_access_unit_if bus_t();

  mem_access_unit dut (
    .clk(clk), .reset(reset), .start(start_a), .op(op), .addr(addr), .store_data(sd),
    .busy(busy_a), .done(done_a), .err(err_a), .load_data(ld_a), .bus(bus_a)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(16'd4)) dut_t (
    .clk(clk), .reset(reset), .start(start_t), .op(op), .addr(addr), .store_data(sd),
    .busy(busy_t), .done(done_t), .err(err_t), .load_data(ld_t), .bus(bus_t)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task issue(input bit to_t, input logic [3:0] o, input logic [31:0] a, input logic [31:0] d);
    op = o;
    addr = a;
    sd = d;
    if (to_t) start_t = 1'b1;
    else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_t = 1'b0;
  endtask

  initial begin
    bus_a.readdata = 32'd0;
    bus_a.waitrequest = 1'b0;
    bus_t.readdata = 32'd0;
    bus_t.waitrequest = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);
    chk("rst_rw", {30'd0, bus_a.read, bus_a.write}, 32'd0);
    chk("rst_be", {28'd0, bus_a.byteenable}, 32'd0);
    chk("rst_addr", bus_a.address, 32'd0);
    chk("rst_wd", bus_a.writedata, 32'd0);
    chk("rst_ld", ld_a, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // SW, zero wait states
    issue(1'b0, 4'd10, 32'hBFC00010, 32'hDEADBEEF);
    chk("sw_write", {30'd0, bus_a.read, bus_a.write}, 32'd1);
    chk("sw_addr", bus_a.address, 32'hBFC00010);
    chk("sw_be", {28'd0, bus_a.byteenable}, 32'hF);
    chk("sw_wd", bus_a.writedata, 32'hDEADBEEF);
    chk("sw_busy", {31'd0, busy_a}, 32'd1);
    chk("sw_nodone", {31'd0, done_a}, 32'd0);
    tick();
    chk("sw_done", {30'd0, done_a, err_a}, 32'b10);
    chk("sw_idle", {29'd0, busy_a, bus_a.read, bus_a.write}, 32'd0);
    tick();
    chk("sw_pulse", {31'd0, done_a}, 32'd0);

    // SB to lane 3
    issue(1'b0, 4'd8, 32'hBFC00013, 32'h00000080);
    chk("sb_be", {28'd0, bus_a.byteenable}, 32'h8);
    chk("sb_wd", bus_a.writedata, 32'h80808080);
    chk("sb_addr", bus_a.address, 32'hBFC00010);
    tick();
    chk("sb_done", {30'd0, done_a, err_a}, 32'b10);

    // LB, then LBU issued in the done cycle
    bus_a.readdata = 32'h80000000;
    issue(1'b0, 4'd0, 32'hBFC00013, 32'd0);
    chk("lb_read", {30'd0, bus_a.read, bus_a.write}, 32'b10);
    chk("lb_be", {28'd0, bus_a.byteenable}, 32'h8);
    tick();
    chk("lb_done", {30'd0, done_a, err_a}, 32'b10);
    chk("lb_data", ld_a, 32'hFFFFFF80);
    issue(1'b0, 4'd4, 32'hBFC00013, 32'd0);
    chk("lbu_b2b", {30'd0, bus_a.read, busy_a}, 32'b11);
    tick();
    chk("lbu_data", ld_a, 32'h00000080);

    // LH upper half, LHU lower half
    bus_a.readdata = 32'h80011234;
    issue(1'b0, 4'd1, 32'hBFC00002, 32'd0);
    chk("lh_be", {28'd0, bus_a.byteenable}, 32'hC);
    tick();
    chk("lh_data", ld_a, 32'hFFFF8001);
    issue(1'b0, 4'd5, 32'hBFC00000, 32'd0);
    chk("lhu_be", {28'd0, bus_a.byteenable}, 32'h3);
    tick();
    chk("lhu_data", ld_a, 32'h00001234);

    // LW with 5 wait states and a stray start mid-transaction
    bus_a.readdata = 32'h12345678;
    bus_a.waitrequest = 1'b1;
    issue(1'b0, 4'd2, 32'hBFC00004, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("ws_read", {30'd0, bus_a.read, bus_a.write}, 32'b10);
      chk("ws_addr", bus_a.address, 32'hBFC00004);
      chk("ws_be", {28'd0, bus_a.byteenable}, 32'hF);
      chk("ws_nodone", {31'd0, done_a}, 32'd0);
      if (i == 2) begin
        op = 4'd10;
        addr = 32'h00000100;
        start_a = 1'b1;
      end
      tick();
      start_a = 1'b0;
    end
    bus_a.waitrequest = 1'b0;
    chk("ws_last", {30'd0, bus_a.read, bus_a.write}, 32'b10);
    chk("ws_addr6", bus_a.address, 32'hBFC00004);
    tick();
    chk("ws_done", {30'd0, done_a, err_a}, 32'b10);
    chk("ws_data", ld_a, 32'h12345678);
    tick();
    chk("ws_ignored", {29'd0, busy_a, bus_a.read, bus_a.write}, 32'd0);

    // Faults: misaligned LW, misaligned SH, illegal op 3
    issue(1'b0, 4'd2, 32'hBFC00002, 32'd0);
    chk("f_lw", {28'd0, done_a, err_a, bus_a.read, bus_a.write}, 32'b1100);
    tick();
    chk("f_lw_after", {28'd0, done_a, err_a, bus_a.read, bus_a.write}, 32'd0);
    issue(1'b0, 4'd9, 32'hBFC00001, 32'h0000AAAA);
    chk("f_sh", {28'd0, done_a, err_a, bus_a.read, bus_a.write}, 32'b1100);
    tick();
    chk("f_sh_after", {28'd0, done_a, err_a, bus_a.read, bus_a.write}, 32'd0);
    issue(1'b0, 4'd3, 32'hBFC00000, 32'd0);
    chk("f_op3", {28'd0, done_a, err_a, bus_a.read, bus_a.write}, 32'b1100);
    tick();
    chk("f_op3_after", {28'd0, done_a, err_a, bus_a.read, bus_a.write}, 32'd0);
    chk("f_ld_kept", ld_a, 32'h12345678);

    // Timeout instance: seed load_data, then stall past the limit
    bus_t.readdata = 32'hCAFEF00D;
    issue(1'b1, 4'd2, 32'hBFC00008, 32'd0);
    tick();
    chk("to_seed", ld_t, 32'hCAFEF00D);
    bus_t.readdata = 32'h0BADBEEF;
    bus_t.waitrequest = 1'b1;
    issue(1'b1, 4'd2, 32'hBFC00008, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("to_stall", {30'd0, bus_t.read, done_t}, 32'b10);
      tick();
    end
    chk("to_done", {28'd0, done_t, err_t, bus_t.read, bus_t.write}, 32'b1100);
    chk("to_ld_kept", ld_t, 32'hCAFEF00D);
    tick();
    chk("to_idle", {31'd0, busy_t}, 32'd0);

    // Reset in the middle of a stalled access
    bus_a.waitrequest = 1'b1;
    issue(1'b0, 4'd2, 32'hBFC00004, 32'd0);
    tick();
    chk("rs_pre", {29'd0, busy_a, bus_a.read, bus_a.write}, 32'b110);
    #2;
    reset = 1'b1;
    #1;
    chk("rs_async", {29'd0, busy_a, bus_a.read, bus_a.write}, 32'd0);
    tick();
    reset = 1'b0;
    chk("rs_nodone", {31'd0, done_a}, 32'd0);
    tick();
    chk("rs_nodone2", {30'd0, done_a, busy_a}, 32'd0);
    bus_a.waitrequest = 1'b0;
    issue(1'b0, 4'd10, 32'hBFC00020, 32'h11223344);
    chk("rs_sw", {30'd0, bus_a.read, bus_a.write}, 32'b01);
    chk("rs_sw_wd", bus_a.writedata, 32'h11223344);
    tick();
    chk("rs_sw_done", {30'd0, done_a, err_a}, 32'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
